// File: rtl/fwd_ctrl.sv
// Distance-1 operand-forwarding controller for a 3-stage (IF/D, X, WB) RISC-V pipeline.
// Decodes the instruction leaving decode and registers mux selects for its stay in X.
module fwd_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_d,
  input  logic        valid_d,
  input  logic        stall,
  input  logic        flush,
  output logic [1:0]  a_sel,
  output logic [1:0]  b_sel,
  output logic [1:0]  rs1_fwd,
  output logic [1:0]  rs2_fwd,
  output logic        x_valid
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [4:0] x_rd;
  logic       x_wen;
  logic       x_load;

  logic       legal, uses_rs1, uses_rs2, writes_rd, is_load, pc_a, imm_b;
  logic       eff_valid;
  logic [4:0] rs1, rs2, rd;
  logic [1:0] fwd1, fwd2;
  logic [1:0] a_sel_n, b_sel_n, rs1_fwd_n, rs2_fwd_n;

  assign rs1 = inst_d[19:15];
  assign rs2 = inst_d[24:20];
  assign rd  = inst_d[11:7];

  always_comb begin
    legal     = 1'b1;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    pc_a      = 1'b0;
    imm_b     = 1'b1;
    unique case (inst_d[6:0])
      OP_R:      begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; imm_b = 1'b0; end
      OP_IALU:   begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
      OP_LOAD:   begin uses_rs1 = 1'b1; writes_rd = 1'b1; is_load = 1'b1; end
      OP_STORE:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; pc_a = 1'b1; end
      OP_JALR:   begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
      OP_JAL:    begin writes_rd = 1'b1; pc_a = 1'b1; end
      OP_LUI:    writes_rd = 1'b1;
      OP_AUIPC:  begin writes_rd = 1'b1; pc_a = 1'b1; end
      default:   legal = 1'b0;
    endcase
  end

  // Flushed, invalid and unrecognised instructions all enter X as bubbles.
  assign eff_valid = valid_d && legal && !flush;

  always_comb begin
    fwd1 = 2'd0;
    fwd2 = 2'd0;
    if (x_valid && x_wen && (x_rd != 5'd0) && (x_rd == rs1))
      fwd1 = x_load ? 2'd3 : 2'd2;
    if (x_valid && x_wen && (x_rd != 5'd0) && (x_rd == rs2))
      fwd2 = x_load ? 2'd3 : 2'd2;
  end

  always_comb begin
    a_sel_n   = 2'd0;
    b_sel_n   = 2'd0;
    rs1_fwd_n = 2'd0;
    rs2_fwd_n = 2'd0;
    if (eff_valid) begin
      if (pc_a)          a_sel_n = 2'd1;
      else if (uses_rs1) a_sel_n = fwd1;
      if (imm_b)         b_sel_n = 2'd1;
      else if (uses_rs2) b_sel_n = fwd2;
      if (uses_rs1) rs1_fwd_n = fwd1;
      if (uses_rs2) rs2_fwd_n = fwd2;
    end
  end

  // A flush kills X even while stalled; otherwise a stall freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_valid <= 1'b0;
      x_wen   <= 1'b0;
      x_load  <= 1'b0;
      x_rd    <= 5'd0;
      a_sel   <= 2'd0;
      b_sel   <= 2'd0;
      rs1_fwd <= 2'd0;
      rs2_fwd <= 2'd0;
    end else if (flush || !stall) begin
      x_valid <= eff_valid;
      x_wen   <= eff_valid && writes_rd;
      x_load  <= eff_valid && is_load;
      x_rd    <= eff_valid ? rd : 5'd0;
      a_sel   <= a_sel_n;
      b_sel   <= b_sel_n;
      rs1_fwd <= rs1_fwd_n;
      rs2_fwd <= rs2_fwd_n;
    end
  end

endmodule
